// File: rtl/uart_bridge_pkg.sv
// Shared constants and FSM encoding for the UART-to-memory command bridge.
package uart_bridge_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] RSP_WACK = 8'hA5;
  localparam logic [7:0] RSP_ERR  = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_MEM,
    ST_RESP
  } state_t;

endpackage

// File: rtl/uart_mem_bridge.sv
// Parses host packets from the uart_comm receive FIFO, performs one word read/write
// on the core's debug bus and returns the response bytes through the send FIFO.
module uart_mem_bridge
  import uart_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int ADDR_W         = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        recv_data,
  input  logic              receivable,
  output logic              recv_flag,
  output logic [7:0]        send_data,
  output logic              send_flag,
  input  logic              sendable,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              timeout
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q;
  logic             we_q;
  logic [1:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      resp_q;
  logic [1:0]       resp_cnt_q;
  logic             mem_req_q;
  logic             timeout_q;
  logic             rdy_q;
  logic             pop;

  // Pop must be combinational so the FIFO head is consumed on the same edge it is
  // captured; rdy_q keeps it low while reset is asserted and for one cycle after.
  assign pop = rdy_q && receivable &&
               (state_q == ST_IDLE || state_q == ST_ADDR || state_q == ST_WDATA);

  assign recv_flag = pop;
  assign send_flag = (state_q == ST_RESP) && sendable;
  assign send_data = resp_q[7:0];
  assign busy      = (state_q != ST_IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q[ADDR_W-1:0];
  assign mem_wdata = wdata_q;
  assign timeout   = timeout_q;

  // NOTE: every register here is assigned with <= so all next-state terms read the
  // pre-edge values; a blocking = would leak updated values into later statements.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      idx_q      <= 2'd0;
      cnt_q      <= '0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      resp_q     <= 32'h0;
      resp_cnt_q <= 2'd0;
      mem_req_q  <= 1'b0;
      timeout_q  <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      rdy_q     <= 1'b1;
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          idx_q <= 2'd0;
          if (pop) begin
            case (recv_data)
              OP_WRITE: begin
                we_q    <= 1'b1;
                state_q <= ST_ADDR;
              end
              OP_READ: begin
                we_q    <= 1'b0;
                state_q <= ST_ADDR;
              end
              default: begin
                resp_q     <= {24'h0, RSP_ERR};
                resp_cnt_q <= 2'd0;
                state_q    <= ST_RESP;
              end
            endcase
          end
        end

        ST_ADDR, ST_WDATA: begin
          if (pop) begin
            cnt_q <= '0;
            idx_q <= idx_q + 2'd1;
            // Little-endian fields: shift each byte in from the top.
            if (state_q == ST_ADDR) begin
              addr_q <= {recv_data, addr_q[31:8]};
            end else begin
              wdata_q <= {recv_data, wdata_q[31:8]};
            end
            if (idx_q == 2'd3) begin
              if (state_q == ST_ADDR && we_q) begin
                state_q <= ST_WDATA;
              end else begin
                state_q <= ST_MEM;
              end
            end
          end else if (cnt_q == CNT_LAST) begin
            cnt_q     <= '0;
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_MEM: begin
          if (!mem_req_q) begin
            mem_req_q <= 1'b1;
          end else if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_RESP;
            if (we_q) begin
              resp_q     <= {24'h0, RSP_WACK};
              resp_cnt_q <= 2'd0;
            end else begin
              resp_q     <= mem_rdata;
              resp_cnt_q <= 2'd3;
            end
          end
        end

        ST_RESP: begin
          if (sendable) begin
            resp_q <= {8'h0, resp_q[31:8]};
            if (resp_cnt_q == 2'd0) begin
              state_q <= ST_IDLE;
            end else begin
              resp_cnt_q <= resp_cnt_q - 2'd1;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Randomized self-checking bench: FIFO/bus responders plus a packet-level reference
// model (expected bytes, transactions and timeouts) compared every clock.
module tb_uart_mem_bridge;

  localparam int TO = 16;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        CLK;
  logic        RST;
  logic [7:0]  recv_data;
  logic        receivable;
  logic        recv_flag;
  logic [7:0]  send_data;
  logic        send_flag;
  logic        sendable;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        timeout;

  uart_mem_bridge #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .recv_data(recv_data), .receivable(receivable), .recv_flag(recv_flag),
    .send_data(send_data), .send_flag(send_flag), .sendable(sendable),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .timeout(timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state and scoreboards
  logic [7:0]  rxq[$];
  logic [7:0]  exp_tx[$];
  txn_t        exp_mem[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] bus_mem[logic [31:0]];
  int          exp_timeouts = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench controls
  bit random_phase = 0;
  bit force_low    = 0;
  int fixed_delay  = 0;

  // Monitor-side observations
  int cyc          = 0;
  int last_pop_cyc = 0;
  int n_push       = 0;
  int n_req_cycles = 0;
  int act_timeouts = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  function automatic logic [31:0] bus_read(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : mem_init(a);
  endfunction

  // Packet-level model: what each packet must produce on the bus and the send FIFO
  task automatic push_write(input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    rxq.push_back(8'h01);
    for (int i = 0; i < 4; i++) rxq.push_back(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) rxq.push_back(d[8*i +: 8]);
    t.we = 1'b1; t.addr = a; t.wdata = d;
    exp_mem.push_back(t);
    ref_mem[a] = d;
    exp_tx.push_back(8'hA5);
  endtask

  task automatic push_read(input logic [31:0] a);
    txn_t        t;
    logic [31:0] v;
    rxq.push_back(8'h02);
    for (int i = 0; i < 4; i++) rxq.push_back(a[8*i +: 8]);
    t.we = 1'b0; t.addr = a; t.wdata = 32'h0;
    exp_mem.push_back(t);
    v = ref_read(a);
    for (int i = 0; i < 4; i++) exp_tx.push_back(v[8*i +: 8]);
  endtask

  // FIFO and bus responder: samples handshakes on the falling edge, drives after rise
  initial begin
    int age;
    int cur_delay;
    int off_run;
    bit new_req;
    bit rx_allow;
    bit s_pop;
    bit s_wr;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    age = 0; cur_delay = 0; off_run = 0; new_req = 1; rx_allow = 1;
    receivable = 1'b0; recv_data = 8'h0; sendable = 1'b1;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge CLK);
      s_pop   = recv_flag;
      s_wr    = mem_req && mem_ack && mem_we;
      s_addr  = mem_addr;
      s_wdata = mem_wdata;
      @(posedge CLK);
      #1;
      if (s_pop && rxq.size() > 0) void'(rxq.pop_front());
      if (s_wr) bus_mem[s_addr] = s_wdata;

      if (!mem_req) begin
        new_req = 1; age = 0;
      end else if (new_req) begin
        new_req = 0; age = 0;
        cur_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
      end else begin
        age++;
      end
      mem_ack   = mem_req ? (age >= cur_delay) : (random_phase && ($urandom % 3 == 0));
      mem_rdata = (mem_req && mem_ack) ? bus_read(mem_addr) : $urandom;

      // Short random gaps between bytes, never long enough to trip the timeout
      if (random_phase && off_run < 3) rx_allow = ($urandom % 4 != 0);
      else rx_allow = 1;
      off_run    = rx_allow ? 0 : off_run + 1;
      receivable = (rxq.size() > 0) && rx_allow;
      recv_data  = (rxq.size() > 0) ? rxq[0] : 8'($urandom);
      sendable   = force_low ? 1'b0 : (random_phase ? ($urandom % 4 != 0) : 1'b1);
    end
  end

  // Compare process
  bit          prev_req  = 0;
  bit          prev_done = 0;
  logic        h_we;
  logic [31:0] h_addr;
  logic [31:0] h_wdata;

  always @(negedge CLK) begin
    txn_t t;
    cyc++;
    if (RST) begin
      prev_req  = 0;
      prev_done = 0;
    end else begin
      if (recv_flag) begin
        check("pop_gate", {31'h0, receivable}, 32'h1);
        check("pop_while_inactive", {31'h0, mem_req | send_flag}, 32'h0);
        last_pop_cyc = cyc;
      end
      if (send_flag) begin
        check("push_gate", {31'h0, sendable}, 32'h1);
        if (exp_tx.size() == 0) check("tx_unexpected", 32'(exp_tx.size()), 32'h1);
        else check("tx_byte", {24'h0, send_data}, {24'h0, exp_tx.pop_front()});
        n_push++;
      end
      if (prev_done && sendable) check("push_after_ack", {31'h0, send_flag}, 32'h1);
      if (prev_req && !prev_done) check("req_held", {31'h0, mem_req}, 32'h1);
      if (prev_done) check("req_drop", {31'h0, mem_req}, 32'h0);
      if (mem_req) begin
        n_req_cycles++;
        if (!prev_req) begin
          check("req_latency", 32'(cyc - last_pop_cyc), 32'd2);
          h_we = mem_we; h_addr = mem_addr; h_wdata = mem_wdata;
        end else begin
          check("we_stable", {31'h0, mem_we}, {31'h0, h_we});
          check("addr_stable", mem_addr, h_addr);
          check("wdata_stable", mem_wdata, h_wdata);
        end
        if (mem_ack) begin
          if (exp_mem.size() == 0) begin
            check("mem_unexpected", 32'(exp_mem.size()), 32'h1);
          end else begin
            t = exp_mem.pop_front();
            check("mem_we", {31'h0, mem_we}, {31'h0, t.we});
            check("mem_addr", mem_addr, t.addr);
            if (t.we) check("mem_wdata", mem_wdata, t.wdata);
          end
        end
      end
      if (timeout) begin
        act_timeouts++;
        check("busy_at_timeout", {31'h0, busy}, 32'h0);
        check("timeout_latency", 32'(cyc - last_pop_cyc), 32'(TO + 1));
      end
      prev_req  = mem_req;
      prev_done = mem_req && mem_ack;
    end
  end

  task automatic wait_rx_empty();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge CLK);
      #3;
      done = (rxq.size() == 0);
    end
    check("rx_drain", {31'h0, done}, 32'h1);
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge CLK);
      #3;
      done = (rxq.size() == 0) && (exp_tx.size() == 0) && (exp_mem.size() == 0) &&
             !busy && !mem_req;
    end
    check("drain", {31'h0, done}, 32'h1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  pkt_w[9];
    logic [7:0]  pkt_r[5];
    logic [31:0] a;
    int          r0;
    int          p0;
    int          k;
    bit          seen;

    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #3;
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_send_flag", {31'h0, send_flag}, 32'h0);
    check("rst_recv_flag", {31'h0, recv_flag}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_timeout", {31'h0, timeout}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #3;

    // Directed write, ack three cycles after request
    fixed_delay = 3;
    pkt_w = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    foreach (pkt_w[i]) rxq.push_back(pkt_w[i]);
    exp_mem.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF});
    exp_tx.push_back(8'hA5);
    ref_mem[32'h10] = 32'hDEAD_BEEF;
    r0 = n_req_cycles;
    drain();
    check("write_req_cycles", 32'(n_req_cycles - r0), 32'd4);

    // Directed read, immediate ack
    fixed_delay = 0;
    bus_mem[32'h20] = 32'h1234_5678;
    ref_mem[32'h20] = 32'h1234_5678;
    pkt_r = '{8'h02, 8'h20, 8'h00, 8'h00, 8'h00};
    foreach (pkt_r[i]) rxq.push_back(pkt_r[i]);
    exp_mem.push_back('{1'b0, 32'h0000_0020, 32'h0});
    exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
    exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
    r0 = n_req_cycles;
    drain();
    check("read_req_cycles", 32'(n_req_cycles - r0), 32'd1);

    // Illegal opcode followed by a valid read
    fixed_delay = 1;
    rxq.push_back(8'h7F);
    exp_tx.push_back(8'hEE);
    push_read(32'h10);
    drain();

    // Partial write then stall beyond the timeout; a full write must follow cleanly
    rxq.push_back(8'h01);
    rxq.push_back(8'h10);
    exp_timeouts++;
    wait_rx_empty();
    repeat (20) @(posedge CLK);
    #3;
    check("timeout_count", 32'(act_timeouts), 32'(exp_timeouts));
    check("busy_after_timeout", {31'h0, busy}, 32'h0);
    push_write(32'h24, 32'h0BAD_F00D);
    drain();

    // Read response with sendable held low mid-response
    foreach (pkt_r[i]) rxq.push_back(pkt_r[i]);
    exp_mem.push_back('{1'b0, 32'h0000_0020, 32'h0});
    exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
    exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
    p0 = n_push;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge CLK);
      #3;
      seen = (n_push > p0);
    end
    check("first_resp_byte", {31'h0, seen}, 32'h1);
    force_low = 1;
    @(posedge CLK);
    #3;
    r0 = n_push;
    check("stall_mid_resp", {31'h0, (r0 - p0) < 4}, 32'h1);
    repeat (4) @(posedge CLK);
    #3;
    check("no_push_while_low", 32'(n_push), 32'(r0));
    force_low = 0;
    drain();

    // Reset while a request is outstanding
    fixed_delay = 40;
    push_read(32'h40);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge CLK);
      #3;
      seen = mem_req;
    end
    check("req_before_reset", {31'h0, seen}, 32'h1);
    RST = 1'b1;
    #1;
    check("rst_async_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_async_busy", {31'h0, busy}, 32'h0);
    check("rst_async_send_flag", {31'h0, send_flag}, 32'h0);
    rxq.delete();
    exp_tx.delete();
    exp_mem.delete();
    repeat (2) @(posedge CLK);
    #3;
    RST = 1'b0;
    fixed_delay = 2;
    push_write(32'h44, 32'hCAFE_F00D);
    push_read(32'h44);
    drain();

    // Randomized traffic against the model
    random_phase = 1;
    fixed_delay  = -1;
    for (int p = 0; p < 60; p++) begin
      r0 = int'($urandom_range(0, 9));
      a  = ($urandom % 8 == 0) ? $urandom : (32'h100 + 32'($urandom_range(0, 7)) * 4);
      if (r0 < 4) begin
        push_write(a, $urandom);
      end else if (r0 < 8) begin
        push_read(a);
      end else if (r0 == 8) begin
        k = int'($urandom_range(0, 255));
        if (k == 1 || k == 2) k = 8'hFF;
        rxq.push_back(8'(k));
        exp_tx.push_back(8'hEE);
      end else begin
        if ($urandom % 2 == 0) begin
          rxq.push_back(8'h01);
          k = int'($urandom_range(0, 7));
        end else begin
          rxq.push_back(8'h02);
          k = int'($urandom_range(0, 3));
        end
        for (int i = 0; i < k; i++) rxq.push_back(8'($urandom));
        exp_timeouts++;
        wait_rx_empty();
        repeat (TO + 4) @(posedge CLK);
        #3;
      end
      if (rxq.size() > 20) wait_rx_empty();
    end
    drain();

    check("final_timeouts", 32'(act_timeouts), 32'(exp_timeouts));
    check("final_tx_empty", 32'(exp_tx.size()), 32'h0);
    check("final_mem_empty", 32'(exp_mem.size()), 32'h0);
    check("final_busy", {31'h0, busy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
